// File: rtl/gsensor_spi_reader.sv
// gsensor_spi_reader: SPI mode-3 master for the on-board ADXL345 accelerometer.
// It runs two init writes (DATA_FORMAT, POWER_CTL) after a startup delay.
// It then burst-reads the acceleration registers once every SAMPLE_PERIOD cycles.
// Define GSENSOR_Z_AXIS_EN to read all six data bytes and drive accel_z.
// Without that macro only X/Y are read, and accel_z is tied to zero.
module gsensor_spi_reader #(
    parameter int CLK_DIV        = 5,
    parameter int STARTUP_CYCLES = 25000,
    parameter int SAMPLE_PERIOD  = 250000
) (
    input  logic        clk_pix,
    input  logic        rst,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        accel_valid,
    output logic        init_done
);

`ifdef GSENSOR_Z_AXIS_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 4;
`endif
    localparam int RX_W = 8 * NBYTES;
    localparam logic [6:0] WR_LAST = 7'd32;
    localparam logic [6:0] RD_LAST = 7'(2 * (8 + RX_W));
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [31:0] STARTUP_LAST = 32'(STARTUP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST = 32'(2 * CLK_DIV - 1);
    localparam logic [31:0] SAMPLE_LAST = 32'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        STARTUP,
        WR_FMT,
        GAP,
        WR_PWR,
        IDLE,
        RD,
        DONE
    } state_t;

    state_t state, state_next;

    logic             in_xfer;
    logic             next_is_xfer;
    logic             start_xfer;
    logic             tick;
    logic             xfer_end;
    logic [6:0]       last_half;
    logic [15:0]      tx_word;
    logic [DIV_W-1:0] div_cnt;
    logic [6:0]       half_cnt;
    logic [31:0]      wait_cnt;
    logic [31:0]      sample_cnt;
    logic             sample_pending;
    logic             sample_expire;
    logic [15:0]      tx_shift;
    logic [RX_W-1:0]  rx_shift;

    // State register
    always_ff @(posedge clk_pix) begin
        if (rst) state <= STARTUP;
        else     state <= state_next;
    end

    // Next-state decode plus transaction framing: half-period ticks, end of frame, word to send
    always_comb begin
        in_xfer    = (state == WR_FMT) || (state == WR_PWR) || (state == RD);
        last_half  = (state == RD) ? RD_LAST : WR_LAST;
        tick       = in_xfer && (div_cnt == DIV_LAST);
        xfer_end   = tick && (half_cnt == last_half);
        state_next = state;
        case (state)
            STARTUP: if (wait_cnt == STARTUP_LAST) state_next = WR_FMT;
            WR_FMT:  if (xfer_end) state_next = GAP;
            GAP:     if (wait_cnt == GAP_LAST) state_next = init_done ? IDLE : WR_PWR;
            WR_PWR:  if (xfer_end) state_next = GAP;
            IDLE:    if (sample_pending) state_next = RD;
            RD:      if (xfer_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = STARTUP;
        endcase
        next_is_xfer = (state_next == WR_FMT) || (state_next == WR_PWR) || (state_next == RD);
        start_xfer   = next_is_xfer && !in_xfer;
        case (state_next)
            WR_FMT:  tx_word = 16'h3108;
            WR_PWR:  tx_word = 16'h2D08;
            default: tx_word = 16'hF200;
        endcase
    end

    // Dwell counter for STARTUP and GAP, cleared on every state change
    always_ff @(posedge clk_pix) begin
        if (rst || (state_next != state)) wait_cnt <= '0;
        else                              wait_cnt <= wait_cnt + 32'd1;
    end

    // Free-running sample timer once init is done; an expiry stays pending until IDLE takes it
    always_comb begin
        sample_expire = init_done && (sample_cnt == SAMPLE_LAST);
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sample_cnt     <= '0;
            sample_pending <= 1'b0;
        end else begin
            if (init_done) sample_cnt <= sample_expire ? 32'd0 : sample_cnt + 32'd1;
            sample_pending <= sample_expire || (sample_pending && !(state == IDLE));
        end
    end

    // SPI shifter: half 0 is CS setup, odd halves are SCLK low, the final high half is CS hold
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b1;
            spi_mosi  <= 1'b0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            init_done <= 1'b0;
        end else if (start_xfer) begin
            spi_cs_n <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_shift <= tx_word;
        end else if (in_xfer) begin
            if (tick) begin
                div_cnt <= '0;
                if (xfer_end) begin
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b1;
                    spi_mosi <= 1'b0;
                    half_cnt <= '0;
                    if (state == WR_PWR) init_done <= 1'b1;
                end else begin
                    half_cnt <= half_cnt + 7'd1;
                    if (!half_cnt[0]) begin
                        spi_sclk <= 1'b0;
                        spi_mosi <= tx_shift[15];
                        tx_shift <= {tx_shift[14:0], 1'b0};
                    end else begin
                        spi_sclk <= 1'b1;
                        if (state == RD) rx_shift <= {rx_shift[RX_W-2:0], spi_miso};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Publish X/Y from the shadow register together with the valid strobe (bytes arrive little-endian)
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            accel_x     <= '0;
            accel_y     <= '0;
            accel_valid <= 1'b0;
        end else begin
            accel_valid <= (state == DONE);
            if (state == DONE) begin
                accel_x <= {rx_shift[RX_W-9 -: 8],  rx_shift[RX_W-1 -: 8]};
                accel_y <= {rx_shift[RX_W-25 -: 8], rx_shift[RX_W-17 -: 8]};
            end
        end
    end

`ifdef GSENSOR_Z_AXIS_EN
    // Publish Z on the same DONE cycle as X/Y
    always_ff @(posedge clk_pix) begin
        if (rst)                 accel_z <= '0;
        else if (state == DONE)  accel_z <= {rx_shift[RX_W-41 -: 8], rx_shift[RX_W-33 -: 8]};
    end
`else
    assign accel_z = 16'h0000;
`endif

endmodule

// File: tb/tb_gsensor_spi_reader.sv
// tb_gsensor_spi_reader: bench with an ADXL345 SPI slave model and scoreboard queues.
// Expected writes and samples are queued when stimulus is driven.
// Monitors pop and compare them when the DUT finishes a frame or strobes accel_valid.
// It follows the GSENSOR_Z_AXIS_EN macro the same way the design does.
module tb_gsensor_spi_reader;
    localparam int CLK_DIV        = 3;
    localparam int STARTUP_CYCLES = 200;
    localparam int SAMPLE_PERIOD  = 2000;
`ifdef GSENSOR_Z_AXIS_EN
    localparam int NBYTES = 6;
`else
    localparam int NBYTES = 4;
`endif
    localparam int RD_PERIODS = 8 + 8 * NBYTES;

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs_n, spi_sclk, spi_mosi, spi_miso;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        accel_valid, init_done;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    gsensor_spi_reader #(
        .CLK_DIV(CLK_DIV),
        .STARTUP_CYCLES(STARTUP_CYCLES),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk_pix(clk_pix),
        .rst(rst),
        .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .accel_x(accel_x),
        .accel_y(accel_y),
        .accel_z(accel_z),
        .accel_valid(accel_valid),
        .init_done(init_done)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkNear(input string tag, input int observed, input int expected, input int tol);
        tests_run++;
        assert ((observed >= expected - tol) && (observed <= expected + tol)) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d +/- %0d", tag, observed, expected, tol);
        end
    endtask

    // ADXL345 model: captures MOSI on rising SCLK, drives MISO on falling SCLK
    logic [7:0]  rd_bytes [6];
    logic        force_en = 1'b0;
    logic        force_val = 1'b0;
    logic        miso_model = 1'b0;
    int          bit_cnt = 0;
    int          data_idx;
    logic [15:0] mosi_cap = '0;
    logic [7:0]  cmd = '0;

    assign spi_miso = force_en ? force_val : miso_model;

    always @(negedge spi_cs_n) begin
        bit_cnt  = 0;
        mosi_cap = '0;
        cmd      = '0;
    end

    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            if (bit_cnt < 16) mosi_cap = {mosi_cap[14:0], spi_mosi};
            bit_cnt++;
            if (bit_cnt == 8) cmd = mosi_cap[7:0];
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n && bit_cnt >= 8 && cmd[7]) begin
            data_idx = bit_cnt - 8;
            if (data_idx < 48) miso_model = rd_bytes[data_idx / 8][7 - (data_idx % 8)];
            else               miso_model = 1'b0;
        end else begin
            miso_model = 1'b0;
        end
    end

    // Scoreboard queues and frame/valid monitors
    logic [15:0] exp_wr [$];
    logic [47:0] exp_rd [$];
    int          valid_times [$];
    int          valid_cnt = 0;
    int          cs_rise_cyc = 0;
    logic        cs_prev = 1'b1;
    logic [15:0] wr_exp_word;
    logic [47:0] rd_exp_sample;

    always @(negedge clk_pix) begin
        if (!cs_prev && spi_cs_n && !rst) begin
            cs_rise_cyc = cyc;
            if (cmd[7]) begin
                checkOutput("rd_cmd", 64'(cmd), 64'h00F2);
                checkOutput("rd_periods", 64'(bit_cnt), 64'(RD_PERIODS));
            end else begin
                checkOutput("wr_queue_nonempty", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    wr_exp_word = exp_wr.pop_front();
                    checkOutput("wr_word", 64'(mosi_cap), 64'(wr_exp_word));
                    checkOutput("wr_periods", 64'(bit_cnt), 64'd16);
                    checkOutput("init_done_after_wr", 64'(init_done), 64'(wr_exp_word == 16'h2D08));
                end
            end
        end
        cs_prev = spi_cs_n;
    end

    always @(negedge clk_pix) begin
        if (accel_valid === 1'b1) begin
            valid_cnt++;
            valid_times.push_back(cyc);
            checkOutput("valid_latency", 64'(cyc - cs_rise_cyc), 64'd1);
            checkOutput("rd_queue_nonempty", 64'(exp_rd.size() != 0), 64'd1);
            if (exp_rd.size() != 0) begin
                rd_exp_sample = exp_rd.pop_front();
                checkOutput("sample_xyz", 64'({accel_x, accel_y, accel_z}), 64'(rd_exp_sample));
            end
        end
    end

    // Load the slave model for the next read and queue the sample the DUT should publish
    task automatic applyStimulus(input logic [47:0] bytes_in, input logic f_en, input logic f_val);
        logic [15:0] ex, ey, ez;
        for (int i = 0; i < 6; i++) rd_bytes[i] = bytes_in[47 - 8 * i -: 8];
        force_en  = f_en;
        force_val = f_val;
        if (f_en) begin
            ex = {16{f_val}};
            ey = {16{f_val}};
            ez = {16{f_val}};
        end else begin
            ex = {rd_bytes[1], rd_bytes[0]};
            ey = {rd_bytes[3], rd_bytes[2]};
            ez = {rd_bytes[5], rd_bytes[4]};
        end
`ifndef GSENSOR_Z_AXIS_EN
        ez = 16'h0000;
`endif
        exp_rd.push_back({ex, ey, ez});
    endtask

    task automatic waitValid(input int target, input string tag);
        int n;
        n = 0;
        while (valid_cnt < target && n < SAMPLE_PERIOD + 1000) begin
            @(negedge clk_pix);
            n++;
        end
        checkOutput(tag, 64'(valid_cnt >= target), 64'd1);
    endtask

    task automatic waitInitDone(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < STARTUP_CYCLES + 1000) begin
            @(negedge clk_pix);
            n++;
        end
        checkOutput(tag, 64'(init_done), 64'd1);
    endtask

    initial begin
        int   n, t0, rises, vcount;
        logic prev;
        for (int i = 0; i < 6; i++) rd_bytes[i] = 8'h00;

        rst = 1'b1;
        repeat (5) @(negedge clk_pix);
        checkOutput("reset_cs_n", 64'(spi_cs_n), 64'd1);
        checkOutput("reset_sclk", 64'(spi_sclk), 64'd1);
        checkOutput("reset_mosi", 64'(spi_mosi), 64'd0);
        checkOutput("reset_xyz", 64'({accel_x, accel_y, accel_z}), 64'd0);
        checkOutput("reset_valid", 64'(accel_valid), 64'd0);
        checkOutput("reset_init_done", 64'(init_done), 64'd0);

        exp_wr.push_back(16'h3108);
        exp_wr.push_back(16'h2D08);
        rst = 1'b0;
        t0 = cyc;
        n = 0;
        while (spi_cs_n !== 1'b0 && n < STARTUP_CYCLES + 100) begin
            @(negedge clk_pix);
            n++;
        end
        checkNear("startup_delay", cyc - t0, STARTUP_CYCLES, 2);

        waitInitDone("init_done_rise");
        @(negedge clk_pix);
        checkOutput("wr_queue_drained", 64'(exp_wr.size()), 64'd0);

        applyStimulus(48'h34_12_FE_FF_00_01, 1'b0, 1'b0);
        waitValid(1, "read1_done");
        applyStimulus(48'h78_56_01_80_CD_AB, 1'b0, 1'b0);
        waitValid(2, "read2_done");
        applyStimulus(48'h00_80_FF_7F_55_AA, 1'b0, 1'b0);
        waitValid(3, "read3_done");
        if (valid_times.size() >= 3) begin
            checkNear("period_1_2", valid_times[1] - valid_times[0], SAMPLE_PERIOD, 1);
            checkNear("period_2_3", valid_times[2] - valid_times[1], SAMPLE_PERIOD, 1);
        end

        applyStimulus(48'h0, 1'b1, 1'b1);
        waitValid(4, "stuck_high_done");
        applyStimulus(48'h0, 1'b1, 1'b0);
        waitValid(5, "stuck_low_done");
        force_en = 1'b0;

        n = 0;
        while (spi_cs_n !== 1'b0 && n < SAMPLE_PERIOD + 1000) begin
            @(negedge clk_pix);
            n++;
        end
        checkOutput("abort_read_start", 64'(spi_cs_n), 64'd0);
        rises = 0;
        prev  = spi_sclk;
        n = 0;
        while (rises < 20 && n < 1000) begin
            @(negedge clk_pix);
            n++;
            if (spi_sclk && !prev) rises++;
            prev = spi_sclk;
        end
        checkOutput("abort_sclk_count", 64'(rises), 64'd20);
        exp_wr.push_back(16'h3108);
        exp_wr.push_back(16'h2D08);
        vcount = valid_cnt;
        rst = 1'b1;
        @(negedge clk_pix);
        checkOutput("abort_cs_n", 64'(spi_cs_n), 64'd1);
        checkOutput("abort_sclk", 64'(spi_sclk), 64'd1);
        checkOutput("abort_init_done", 64'(init_done), 64'd0);
        repeat (2) @(negedge clk_pix);
        rst = 1'b0;

        waitInitDone("reinit_done");
        @(negedge clk_pix);
        checkOutput("reinit_wr_drained", 64'(exp_wr.size()), 64'd0);
        checkOutput("abort_no_valid", 64'(valid_cnt), 64'(vcount));

        applyStimulus(48'h0F_F0_3C_C3_99_66, 1'b0, 1'b0);
        waitValid(vcount + 1, "read_after_reinit");
        checkOutput("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
